// File: rtl/regfile_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_scheduler
// Purpose  : Arbitrates ALU/MEM writebacks onto the register-file write port
//            and keeps a destination scoreboard for the issue stage.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_scheduler #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        WrClk,
  input  logic        Reset,
  input  logic        IssueValid,
  input  logic [4:0]  IssueRd,
  output logic        IssueReady,
  input  logic [4:0]  Ra,
  input  logic [4:0]  Rb,
  output logic        HazardA,
  output logic        HazardB,
  input  logic        AluValid,
  input  logic [4:0]  AluRd,
  input  logic [31:0] AluData,
  output logic        AluReady,
  input  logic        MemValid,
  input  logic [4:0]  MemRd,
  input  logic [31:0] MemData,
  output logic        MemReady,
  output logic [4:0]  Rw,
  output logic        RegWr,
  output logic [31:0] busW,
  output logic [31:0] Busy
);

  localparam int              c_CW    = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [c_CW-1:0] c_LIMIT = c_CW'(STARVE_LIMIT);

  logic [31:0]     r_busy;
  logic [c_CW-1:0] r_starve;
  logic [4:0]      r_rw;
  logic            r_regwr;
  logic [31:0]     r_busw;

  logic            w_alu_gnt;
  logic            w_mem_gnt;
  logic [4:0]      w_gnt_rd;
  logic [31:0]     w_gnt_data;
  logic [31:0]     w_set;
  logic [31:0]     w_clr;
  logic [31:0]     w_busy_nxt;

  // Issue-side views use the scoreboard as registered; no write-stage bypass.
  assign IssueReady = !(r_busy[IssueRd] && (IssueRd != 5'd0));
  assign HazardA    = r_busy[Ra] && (Ra != 5'd0);
  assign HazardB    = r_busy[Rb] && (Rb != 5'd0);

  // MEM has priority; ALU wins when alone or once it has lost STARVE_LIMIT times.
  assign w_alu_gnt  = AluValid && (!MemValid || (r_starve == c_LIMIT));
  assign w_mem_gnt  = MemValid && !w_alu_gnt;
  assign AluReady   = w_alu_gnt;
  assign MemReady   = w_mem_gnt;
  assign w_gnt_rd   = w_alu_gnt ? AluRd   : MemRd;
  assign w_gnt_data = w_alu_gnt ? AluData : MemData;

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (IssueValid && IssueReady) begin
      w_set[IssueRd] = 1'b1;
    end
    w_set[0] = 1'b0;
    if (r_regwr) begin
      w_clr[r_rw] = 1'b1;
    end
    // A same-edge allocation of the retiring register keeps the bit set.
    w_busy_nxt = (r_busy & ~w_clr) | w_set;
  end

  always_ff @(posedge WrClk or posedge Reset) begin
    if (Reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  always_ff @(posedge WrClk or posedge Reset) begin
    if (Reset) begin
      r_starve <= '0;
    end else if (!AluValid || w_alu_gnt) begin
      r_starve <= '0;
    end else if (w_mem_gnt && (r_starve != c_LIMIT)) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  always_ff @(posedge WrClk or posedge Reset) begin
    if (Reset) begin
      r_rw    <= '0;
      r_regwr <= 1'b0;
      r_busw  <= '0;
    end else if (w_alu_gnt || w_mem_gnt) begin
      r_rw    <= w_gnt_rd;
      r_busw  <= w_gnt_data;
      r_regwr <= (w_gnt_rd != 5'd0);
    end else begin
      r_regwr <= 1'b0;
    end
  end

  assign Rw    = r_rw;
  assign RegWr = r_regwr;
  assign busW  = r_busw;
  assign Busy  = r_busy;

endmodule
`default_nettype wire
